// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use, taken-branch
// flush and multi-cycle MAC stalls, plus a stall-cycle counter and MAC timeout flag.
module pipeline_hazard_controller #(
    parameter int unsigned MAC_TIMEOUT  = 64,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             PCSrcM,
    input  logic             MacStartE,
    input  logic             MacDone,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             MacErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MAC_WAIT = 2'd1,
        FLUSH    = 2'd2,
        UNUSED   = 2'd3
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);
    localparam logic [7:0] MAC_LAST   = 8'(MAC_TIMEOUT - 1);

    state_t     state, next_state;
    logic [1:0] fcnt, fcnt_next;
    logic [7:0] mcnt, mcnt_next;
    logic       err_set;
    logic       load_use;
    logic       sf, sd, se, fd, fe;

    assign load_use = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        next_state = state;
        fcnt_next  = fcnt;
        mcnt_next  = mcnt;
        err_set    = 1'b0;
        sf = 1'b0; sd = 1'b0; se = 1'b0; fd = 1'b0; fe = 1'b0;
        case (state)
            RUN: begin
                if (PCSrcM) begin
                    fd = 1'b1; fe = 1'b1;
                    next_state = FLUSH;
                    fcnt_next  = FLUSH_LOAD;
                end else if (load_use) begin
                    sf = 1'b1; sd = 1'b1; fe = 1'b1;
                end else if (MacStartE) begin
                    sf = 1'b1; sd = 1'b1; se = 1'b1;
                    mcnt_next = '0;
                    if (!MacDone) next_state = MAC_WAIT;
                end
            end
            MAC_WAIT: begin
                // A branch here is illegal; handle it like RUN so the pipe never wedges.
                if (PCSrcM) begin
                    fd = 1'b1; fe = 1'b1;
                    next_state = FLUSH;
                    fcnt_next  = FLUSH_LOAD;
                end else begin
                    sf = 1'b1; sd = 1'b1; se = 1'b1;
                    mcnt_next = mcnt + 8'd1;
                    if (MacDone) begin
                        next_state = RUN;
                    end else if (mcnt == MAC_LAST) begin
                        err_set    = 1'b1;
                        next_state = RUN;
                    end
                end
            end
            FLUSH: begin
                fd = 1'b1;
                if (PCSrcM) begin
                    fe = 1'b1;
                    fcnt_next = FLUSH_LOAD;
                end else begin
                    fcnt_next = fcnt - 2'd1;
                    if (fcnt <= 2'd1) next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    assign StallF = sf & ~rst;
    assign StallD = sd & ~rst;
    assign StallE = se & ~rst;
    assign FlushD = fd & ~rst;
    assign FlushE = fe & ~rst;
    assign State  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            fcnt     <= '0;
            mcnt     <= '0;
            MacErr   <= 1'b0;
            StallCnt <= '0;
        end else begin
            state <= next_state;
            fcnt  <= fcnt_next;
            mcnt  <= mcnt_next;
            if (err_set) MacErr <= 1'b1;
            if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the fetch stage enable (EN, active-low update) and the decode clear (CLR), plus the execute-stage stall and flush. It handles three cases: load-use hazards, taken branches resolved in Memory, and multi-cycle matrix-MAC operations issued from Execute. It also keeps a saturating stall-cycle performance counter and a sticky MAC-timeout error flag.

Parameters:
MAC_TIMEOUT, 64, maximum cycles spent in MAC_WAIT before a forced exit; legal range 2..255.
FLUSH_CYCLES, 1, extra cycles FlushD is held after the branch cycle; legal range 1..3.
CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-high
Rs1D  in  5  rs1 of the instruction in Decode
Rs2D  in  5  rs2 of the instruction in Decode
RdE  in  5  rd of the instruction in Execute
LoadE  in  1  instruction in Execute is a load (ResultSrcE selects memory)
PCSrcM  in  1  taken branch or jump resolved in Memory
MacStartE  in  1  matrix-MAC instruction valid in Execute
MacDone  in  1  one-cycle pulse from the MAC unit: result ready
StallF  out  1  1 = hold PC and fetch register (wired to fetch EN)
StallD  out  1  1 = hold Decode register
StallE  out  1  1 = hold Execute register
FlushD  out  1  1 = clear Decode register (wired to fetch CLR)
FlushE  out  1  1 = insert bubble into Execute
MacErr  out  1  sticky: MAC_WAIT exited by timeout
StallCnt  out  CNT_W  cycles with StallF = 1, saturating
State  out  2  current FSM state, for debug

Behaviour:
- Reset (async, rst = 1):
  - State = RUN (2'd0); flush counter = 0; MAC counter = 0; MacErr = 0; StallCnt = 0.
  - All stall/flush outputs = 0 while rst is high.
  - Reset in any state aborts that state immediately.
- States: RUN = 0, MAC_WAIT = 1, FLUSH = 2; encoding 3 is unused and recovers to RUN on the next clock.
- Stall/flush outputs are combinational (Mealy) from State and the inputs. State and counters update on the clk rising edge.
- RUN, evaluated in priority order:
  1. PCSrcM = 1:
     - FlushD = 1 and FlushE = 1 this cycle; no stalls.
     - Next state = FLUSH; flush counter loaded with FLUSH_CYCLES.
     - Flush overrides any simultaneous load-use hazard or MacStartE.
  2. Load-use hazard, defined as LoadE & (RdE != 0) & (RdE == Rs1D or RdE == Rs2D):
     - StallF = 1, StallD = 1, FlushE = 1 for exactly that cycle.
     - State stays RUN; the hazard clears naturally next cycle.
     - RdE = x0 never stalls.
  3. MacStartE = 1:
     - StallF = StallD = StallE = 1 starting in the same cycle.
     - Next state = MAC_WAIT; MAC counter cleared to 0.
     - If MacDone = 1 in that same cycle, the operation completes immediately: no MAC_WAIT entry, and the stall is one cycle only.
- MAC_WAIT:
  - StallF = StallD = StallE = 1 and FlushE = 0; the MAC counter increments each cycle.
  - MacDone = 1: stalls still asserted this cycle; next state = RUN.
  - MAC counter == MAC_TIMEOUT-1 without MacDone: set MacErr = 1; next state = RUN.
  - PCSrcM = 1 (illegal while E is stalled):
    - Treated as in RUN: FlushD = FlushE = 1, stalls deasserted, next state = FLUSH.
    - MacDone is ignored that cycle.
- FLUSH:
  - FlushD = 1, FlushE = 0, no stalls; flush counter decrements each cycle; at 1, next state = RUN.
  - PCSrcM = 1 again: FlushE = 1 as well, and the flush counter reloads to FLUSH_CYCLES.
  - Load-use and MacStartE are ignored, because the wrong-path instructions are being flushed.
- StallCnt increments by 1 on every clock edge where StallF = 1 and rst = 0. It holds at 2^CNT_W-1.
- MacErr clears only on reset.

Test Plan:
1. Reset then idle: rst = 1 for 2 cycles, then 0, all inputs 0 → State = 0, all stall/flush outputs = 0, StallCnt = 0, MacErr = 0 for 10 cycles.
2. Load-use: LoadE = 1, RdE = 5, Rs2D = 5 for one cycle → StallF = StallD = FlushE = 1 that cycle only, StallCnt = 1. Repeat with RdE = 0 → no stall.
3. Branch with FLUSH_CYCLES = 1: PCSrcM pulse in cycle N, simultaneous with a load-use hazard → cycle N: FlushD = FlushE = 1, StallF = 0. Cycle N+1: FlushD = 1, State = 2. Cycle N+2: State = 0.
4. MAC normal: MacStartE in cycle N, MacDone in cycle N+5 → StallF = StallD = StallE = 1 in cycles N..N+5, released at N+6, StallCnt = 6, MacErr = 0.
5. MAC timeout with MAC_TIMEOUT = 8: MacStartE, MacDone never asserted → return to RUN after 8 cycles in MAC_WAIT, MacErr = 1 and remains 1 until rst.
6. Mid-operation reset: rst asserted asynchronously in cycle 3 of MAC_WAIT → outputs drop to 0 immediately. After release: State = 0, StallCnt = 0.
